hilo_unit: RTL

- Sequential HI/LO register unit; sits directly downstream of the combinational 32×32 multiplier in the single-cycle CPU datapath.
- Accepts MULT/MULTU/MTHI/MTLO requests from decode and drives operands and sign mode to the multiplier.
- Models a fixed multi-cycle multiply latency with a busy/ready handshake, then commits the multiplier's HI/LO outputs into architectural HI/LO registers for MFHI/MFLO.

---
 rtl/hilo_unit_if.sv | 19 +
 rtl/hilo_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/hilo_unit_if.sv
// Decode-side request handshake for hilo_unit: request fields in, ready/busy back.
interface hilo_unit_if;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        op_ready;
   logic        busy;

   modport master (
      output op_valid, op_code, rs_data, rt_data,
      input  op_ready, busy
   );

   modport slave (
      input  op_valid, op_code, rs_data, rt_data,
      output op_ready, busy
   );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register unit: launches MULT/MULTU into an external multiplier, waits MUL_LAT cycles, commits HI/LO.
// Optional macro HILO_BYPASS_EN forwards commit/MTHI/MTLO data to hi/lo one cycle early.
module hilo_unit #(
   parameter int unsigned MUL_LAT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   hilo_unit_if.slave  req,
   output logic        mul_sign,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [31:0] mul_hi,
   input  logic [31:0] mul_lo,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_MTHI  = 3'b011;
   localparam logic [2:0] OP_MTLO  = 3'b100;
   localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        mul_sign_q, mul_sign_d;
   logic [31:0] mul_a_q, mul_a_d;
   logic [31:0] mul_b_q, mul_b_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic busy_w;
   logic accept;
   logic commit;
   logic wr_hi;
   logic wr_lo;

   assign busy_w       = (state_q == RUN);
   assign req.busy     = busy_w;
   assign req.op_ready = !busy_w;
   // Acceptance is only possible in IDLE, so the write strobes need no state term.
   assign accept = req.op_valid && !busy_w;
   assign commit = (state_q == RUN) && (cnt_q == 4'd0);
   assign wr_hi  = accept && (req.op_code == OP_MTHI);
   assign wr_lo  = accept && (req.op_code == OP_MTLO);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mul_sign_d = mul_sign_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      case (state_q)
         IDLE: begin
            if (accept && (req.op_code == OP_MULT || req.op_code == OP_MULTU)) begin
               mul_a_d    = req.rs_data;
               mul_b_d    = req.rt_data;
               mul_sign_d = (req.op_code == OP_MULT);
               cnt_d      = CNT_INIT;
               state_d    = RUN;
            end
            if (wr_hi) hi_d = req.rs_data;
            if (wr_lo) lo_d = req.rs_data;
         end
         RUN: begin
            if (commit) begin
               hi_d    = mul_hi;
               lo_d    = mul_lo;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         mul_sign_q <= 1'b0;
         mul_a_q    <= 32'd0;
         mul_b_q    <= 32'd0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mul_sign_q <= mul_sign_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign mul_sign = mul_sign_q;
   assign mul_a    = mul_a_q;
   assign mul_b    = mul_b_q;

`ifdef HILO_BYPASS_EN
   assign hi = commit ? mul_hi : (wr_hi ? req.rs_data : hi_q);
   assign lo = commit ? mul_lo : (wr_lo ? req.rs_data : lo_q);
`else
   assign hi = hi_q;
   assign lo = lo_q;
`endif
endmodule
